panda_pcomp_capture: RTL

Position-capture companion to panda_pcomp: it consumes the position-compare pulse stream and records what happened.
- On each qualifying edge of pulse_i it latches posn_i and a timestamp relative to arming.
- Each capture goes into a small FIFO that downstream readout logic drains with a valid/ready handshake.
- It sits beside panda_pcomp on the position bus and provides the readback path for compare events.

---
 rtl/panda_pcomp_capture_pkg.sv | 21 ++
 rtl/panda_capt_fifo.sv | 71 +++++++
 rtl/panda_pcomp_capture.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/panda_pcomp_capture_pkg.sv
// Shared types for the position-compare capture block: FSM states, the FIFO
// entry layout and the timestamp ceiling.
package panda_pcomp_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // edg: 1 = rising-edge capture, 0 = falling-edge capture
  typedef struct packed {
    logic [31:0] posn;
    logic [31:0] ts;
    logic        edg;
  } capt_entry_t;

  localparam logic [31:0] TS_MAX  = 32'hFFFF_FFFF;
  localparam int          ENTRY_W = $bits(capt_entry_t);

endpackage

// File: rtl/panda_capt_fifo.sv
// Synchronous capture FIFO with a registered first-word-fall-through head.
// A push lands in memory on its clock and is presented on the following one.
module panda_capt_fifo
  import panda_pcomp_capture_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               i_flush,
  input  logic               i_push,
  input  logic [ENTRY_W-1:0] i_din,
  input  logic               i_ready,
  output logic               o_valid,
  output logic [ENTRY_W-1:0] o_dout,
  output logic [AW:0]        o_fill,
  output logic               o_acc,
  output logic               o_drop
);

  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [AW:0]        r_wcnt;
  logic [AW:0]        r_rcnt;
  logic               r_valid;
  logic [ENTRY_W-1:0] r_dout;

  logic [AW:0] w_fill;
  logic [AW:0] w_rcnt_nxt;
  logic [AW:0] w_left;
  logic        w_full;
  logic        w_pop;

  assign w_fill     = r_wcnt - r_rcnt;
  assign w_full     = (w_fill == (AW+1)'(DEPTH));
  assign w_pop      = r_valid && i_ready;
  // A pop frees the head slot on the same clock, so a full FIFO still accepts.
  assign o_acc      = i_push && !i_flush && (!w_full || w_pop);
  assign o_drop     = i_push && !i_flush && w_full && !w_pop;
  assign w_rcnt_nxt = r_rcnt + {{AW{1'b0}}, w_pop};
  assign w_left     = r_wcnt - w_rcnt_nxt;

  always_ff @(posedge clk_i) begin
    if (o_acc) begin
      r_mem[r_wcnt[AW-1:0]] <= i_din;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i || i_flush) begin
      r_wcnt  <= '0;
      r_rcnt  <= '0;
      r_valid <= 1'b0;
      r_dout  <= '0;
    end else begin
      if (o_acc) begin
        r_wcnt <= r_wcnt + 1'b1;
      end
      r_rcnt  <= w_rcnt_nxt;
      r_valid <= (w_left != '0);
      if (w_left != '0) begin
        r_dout <= r_mem[w_rcnt_nxt[AW-1:0]];
      end
    end
  end

  assign o_valid = r_valid;
  assign o_dout  = r_dout;
  assign o_fill  = w_fill;

endmodule

// File: rtl/panda_pcomp_capture.sv
// Captures position and arm-relative timestamp on pcomp pulse edges into a FIFO.
// Define PCOMP_CAPT_FALLING_EN to capture falling pulse edges as well.
module panda_pcomp_capture
  import panda_pcomp_capture_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        enable_i,
  input  logic [31:0] posn_i,
  input  logic        pulse_i,
  input  logic        act_i,
  input  logic [31:0] MAX_CAPT,
  input  logic        rd_ready_i,
  output logic        rd_valid_o,
  output logic [31:0] rd_posn_o,
  output logic [31:0] rd_ts_o,
  output logic        rd_edge_o,
  output logic [31:0] count_o,
  output logic [AW:0] fill_o,
  output logic        ovf_o,
  output logic [1:0]  state_o
);

  function automatic logic [31:0] ts_sat_inc(input logic [31:0] v);
    return (v == TS_MAX) ? TS_MAX : v + 32'd1;
  endfunction

  logic        r_pulse_p0, r_pulse_p1;
  logic        r_en_p0, r_en_p1;
  logic        r_act_p0, r_act_p1;
  logic [31:0] r_posn_p0;
  state_e      r_state;
  logic [31:0] r_count;
  logic        r_ovf;
  logic [31:0] r_ts;

  logic        w_en_rise, w_act_fall, w_pulse_edge;
  logic        w_arm, w_push, w_acc, w_drop, w_limit;
  logic [31:0] w_ts_cur, w_count_inc;
  capt_entry_t w_entry, w_dout;
  logic        w_valid;

  // Stage p0: sampled inputs; edges compare against the previous sample (p1).
  always_ff @(posedge clk_i) begin
    r_posn_p0 <= posn_i;
  end

  assign w_en_rise  = r_en_p0 && !r_en_p1;
  assign w_act_fall = r_act_p1 && !r_act_p0;
`ifdef PCOMP_CAPT_FALLING_EN
  assign w_pulse_edge = r_pulse_p0 != r_pulse_p1;
`else
  assign w_pulse_edge = r_pulse_p0 && !r_pulse_p1;
`endif

  // Timestamp of the sampling clock, counting the clock that sampled the arm as 0.
  assign w_ts_cur    = ts_sat_inc(r_ts);
  assign w_count_inc = r_count + 32'd1;
  assign w_limit     = (MAX_CAPT != 32'd0) && (w_count_inc >= MAX_CAPT);
  assign w_arm       = (r_state == ST_IDLE) && w_en_rise;
  assign w_push      = (r_state == ST_ARMED) && r_en_p0 && w_pulse_edge;
  assign w_entry     = '{posn: r_posn_p0, ts: w_ts_cur, edg: r_pulse_p0};

  // Stage p1: control FSM, capture counter, overflow flag and timestamp.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      r_pulse_p0 <= 1'b0;
      r_pulse_p1 <= 1'b0;
      r_en_p0    <= 1'b0;
      r_en_p1    <= 1'b0;
      r_act_p0   <= 1'b0;
      r_act_p1   <= 1'b0;
      r_state    <= ST_IDLE;
      r_count    <= '0;
      r_ovf      <= 1'b0;
      r_ts       <= '0;
    end else begin
      r_pulse_p0 <= pulse_i;
      r_pulse_p1 <= r_pulse_p0;
      r_en_p0    <= enable_i;
      r_en_p1    <= r_en_p0;
      r_act_p0   <= act_i;
      r_act_p1   <= r_act_p0;
      case (r_state)
        ST_IDLE: begin
          if (w_arm) begin
            r_state <= ST_ARMED;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_ts    <= '0;
          end
        end
        ST_ARMED: begin
          if (!r_en_p0) begin
            r_state <= ST_IDLE;
          end else begin
            r_ts <= w_ts_cur;
            if (w_acc) begin
              r_count <= w_count_inc;
            end
            if (w_drop) begin
              r_ovf <= 1'b1;
            end
            if (w_act_fall || (w_acc && w_limit)) begin
              r_state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (!r_en_p0) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  panda_capt_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .i_flush (w_arm),
    .i_push  (w_push),
    .i_din   (w_entry),
    .i_ready (rd_ready_i),
    .o_valid (w_valid),
    .o_dout  (w_dout),
    .o_fill  (fill_o),
    .o_acc   (w_acc),
    .o_drop  (w_drop)
  );

  assign rd_valid_o = w_valid;
  assign rd_posn_o  = w_dout.posn;
  assign rd_ts_o    = w_dout.ts;
  assign rd_edge_o  = w_dout.edg;
  assign count_o    = r_count;
  assign ovf_o      = r_ovf;
  assign state_o    = r_state;

endmodule
